// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator with valid/ready handshakes on both sides,
// a 2-entry skid buffer (output register + skid register) and a sideband tag.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst_code,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [2:0]       fmt,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_SH   = 3'd6;
  localparam logic [2:0] FMT_Z    = 3'd7;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  assign opcode = inst_code[6:0];
  assign funct3 = inst_code[14:12];

  // Signed casts to XLEN sign-extend; unsigned casts zero-extend.
  always_comb begin
    dec_imm     = '0;
    dec_fmt     = FMT_NONE;
    dec_illegal = 1'b0;
    case (opcode)
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_fmt = FMT_SH;
          if (XLEN == 64) dec_imm = XLEN'(inst_code[25:20]);
          else            dec_imm = XLEN'(inst_code[24:20]);
        end else begin
          dec_fmt = FMT_I;
          dec_imm = XLEN'($signed(inst_code[31:20]));
        end
      end
      7'b0000011, 7'b1100111: begin
        dec_fmt = FMT_I;
        dec_imm = XLEN'($signed(inst_code[31:20]));
      end
      7'b0100011: begin
        dec_fmt = FMT_S;
        dec_imm = XLEN'($signed({inst_code[31:25], inst_code[11:7]}));
      end
      7'b1100011: begin
        dec_fmt = FMT_B;
        dec_imm = XLEN'($signed({inst_code[31], inst_code[7], inst_code[30:25],
                                 inst_code[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec_fmt = FMT_U;
        dec_imm = XLEN'($signed({inst_code[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec_fmt = FMT_J;
        dec_imm = XLEN'($signed({inst_code[31], inst_code[19:12], inst_code[20],
                                 inst_code[30:21], 1'b0}));
      end
      7'b1110011: begin
        if (funct3[2]) begin
          dec_fmt = FMT_Z;
          dec_imm = XLEN'(inst_code[19:15]);
        end
      end
      7'b0110011, 7'b0001111: dec_illegal = 1'b0;
      default:                dec_illegal = 1'b1;
    endcase
  end

  logic             or_valid, sk_valid;
  logic [XLEN-1:0]  or_imm, sk_imm;
  logic [2:0]       or_fmt, sk_fmt;
  logic             or_illegal, sk_illegal;
  logic [TAG_W-1:0] or_tag, sk_tag;

  assign in_ready  = !sk_valid;
  assign out_valid = or_valid;
  assign imm_out   = or_imm;
  assign fmt       = or_fmt;
  assign illegal   = or_illegal;
  assign out_tag   = or_tag;

  // When OR is free or draining, it refills from SK first (input stalled), else from the input.
  // A full OR that is not draining parks the input in SK.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      or_valid   <= 1'b0;
      or_imm     <= '0;
      or_fmt     <= FMT_NONE;
      or_illegal <= 1'b0;
      or_tag     <= '0;
      sk_valid   <= 1'b0;
      sk_imm     <= '0;
      sk_fmt     <= FMT_NONE;
      sk_illegal <= 1'b0;
      sk_tag     <= '0;
    end else if (flush) begin
      or_valid <= 1'b0;
      sk_valid <= 1'b0;
    end else if (!or_valid || out_ready) begin
      if (sk_valid) begin
        or_valid   <= 1'b1;
        or_imm     <= sk_imm;
        or_fmt     <= sk_fmt;
        or_illegal <= sk_illegal;
        or_tag     <= sk_tag;
        sk_valid   <= 1'b0;
      end else if (in_valid) begin
        or_valid   <= 1'b1;
        or_imm     <= dec_imm;
        or_fmt     <= dec_fmt;
        or_illegal <= dec_illegal;
        or_tag     <= in_tag;
      end else begin
        or_valid <= 1'b0;
      end
    end else if (in_valid && !sk_valid) begin
      sk_valid   <= 1'b1;
      sk_imm     <= dec_imm;
      sk_fmt     <= dec_fmt;
      sk_illegal <= dec_illegal;
      sk_tag     <= in_tag;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe: decode vectors, backpressure, flush,
// asynchronous reset, plus an XLEN=64 instance for the 64-bit corner cases.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst_code;
  logic [31:0] in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] imm_out;
  logic [2:0]  fmt;
  logic        illegal;
  logic [31:0] out_tag;

  logic        flush64;
  logic        in_valid64;
  logic        in_ready64;
  logic [31:0] inst_code64;
  logic [31:0] in_tag64;
  logic        out_valid64;
  logic        out_ready64;
  logic [63:0] imm_out64;
  logic [2:0]  fmt64;
  logic        illegal64;
  logic [31:0] out_tag64;

  int n_checks = 0;
  int n_fails  = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .inst_code(inst_code), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .imm_out(imm_out), .fmt(fmt),
    .illegal(illegal), .out_tag(out_tag)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush64),
    .in_valid(in_valid64), .in_ready(in_ready64), .inst_code(inst_code64), .in_tag(in_tag64),
    .out_valid(out_valid64), .out_ready(out_ready64), .imm_out(imm_out64), .fmt(fmt64),
    .illegal(illegal64), .out_tag(out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Data fields are only compared when an entry is expected to be valid.
  task automatic checkOutput(input string name, input logic exp_valid, input logic [31:0] exp_imm,
                             input logic [2:0] exp_fmt, input logic exp_ill, input logic [31:0] exp_tag);
    checkValue({name, ".valid"}, 64'(out_valid), 64'(exp_valid));
    if (exp_valid) begin
      checkValue({name, ".imm"}, 64'(imm_out), 64'(exp_imm));
      checkValue({name, ".fmt"}, 64'(fmt), 64'(exp_fmt));
      checkValue({name, ".illegal"}, 64'(illegal), 64'(exp_ill));
      checkValue({name, ".tag"}, 64'(out_tag), 64'(exp_tag));
    end
  endtask

  // Offers one instruction and advances past the next rising edge.
  task automatic applyStimulus(input logic vld, input logic [31:0] inst, input logic [31:0] tag);
    in_valid  = vld;
    inst_code = inst;
    in_tag    = tag;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; inst_code = '0; in_tag = '0; out_ready = 1'b1;
    flush64 = 1'b0; in_valid64 = 1'b0; inst_code64 = '0; in_tag64 = '0; out_ready64 = 1'b1;
    #1;
    $display("[TB] reset state");
    checkValue("rst.out_valid", 64'(out_valid), 64'd0);
    checkValue("rst.imm", 64'(imm_out), 64'd0);
    checkValue("rst.fmt", 64'(fmt), 64'd0);
    checkValue("rst.illegal", 64'(illegal), 64'd0);
    checkValue("rst.tag", 64'(out_tag), 64'd0);
    checkValue("rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] decode vectors, streaming");
    applyStimulus(1'b1, 32'hFFF00093, 32'h100); checkOutput("addi", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h100);
    applyStimulus(1'b1, 32'hFFF04083, 32'h104); checkOutput("lbu", 1'b1, 32'hFFFFFFFF, 3'd1, 1'b0, 32'h104);
    applyStimulus(1'b1, 32'hFE000EE3, 32'h108); checkOutput("beq", 1'b1, 32'hFFFFFFFC, 3'd3, 1'b0, 32'h108);
    applyStimulus(1'b1, 32'h008000EF, 32'h10C); checkOutput("jal", 1'b1, 32'h00000008, 3'd5, 1'b0, 32'h10C);
    applyStimulus(1'b1, 32'h4030D093, 32'h110); checkOutput("srai", 1'b1, 32'h00000003, 3'd6, 1'b0, 32'h110);
    applyStimulus(1'b1, 32'h3402D073, 32'h114); checkOutput("csrrwi", 1'b1, 32'h00000005, 3'd7, 1'b0, 32'h114);
    applyStimulus(1'b1, 32'h0000007F, 32'h118); checkOutput("bad_op", 1'b1, 32'h00000000, 3'd0, 1'b1, 32'h118);
    applyStimulus(1'b1, 32'hFE112E23, 32'h11C); checkOutput("sw", 1'b1, 32'hFFFFFFFC, 3'd2, 1'b0, 32'h11C);
    applyStimulus(1'b1, 32'h12345037, 32'h120); checkOutput("lui", 1'b1, 32'h12345000, 3'd4, 1'b0, 32'h120);
    applyStimulus(1'b1, 32'h00000033, 32'h124); checkOutput("add", 1'b1, 32'h00000000, 3'd0, 1'b0, 32'h124);
    applyStimulus(1'b1, 32'h0000000F, 32'h128); checkOutput("fence", 1'b1, 32'h00000000, 3'd0, 1'b0, 32'h128);
    applyStimulus(1'b1, 32'h00000073, 32'h12C); checkOutput("ecall", 1'b1, 32'h00000000, 3'd0, 1'b0, 32'h12C);
    applyStimulus(1'b1, 32'h03F09093, 32'h130); checkOutput("slli32", 1'b1, 32'h0000001F, 3'd6, 1'b0, 32'h130);
    applyStimulus(1'b0, 32'h0, 32'h0); checkOutput("drain", 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00100093, 32'hA); checkOutput("bp.a", 1'b1, 32'h1, 3'd1, 1'b0, 32'hA);
    checkValue("bp.ready_a", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 32'h00200093, 32'hB); checkOutput("bp.a_hold1", 1'b1, 32'h1, 3'd1, 1'b0, 32'hA);
    checkValue("bp.ready_b", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'h00300093, 32'hC); checkOutput("bp.a_hold2", 1'b1, 32'h1, 3'd1, 1'b0, 32'hA);
    checkValue("bp.ready_c1", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 32'h00300093, 32'hC); checkOutput("bp.a_hold3", 1'b1, 32'h1, 3'd1, 1'b0, 32'hA);
    out_ready = 1'b1;
    applyStimulus(1'b1, 32'h00300093, 32'hC); checkOutput("bp.b", 1'b1, 32'h2, 3'd1, 1'b0, 32'hB);
    checkValue("bp.ready_after", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 32'h00300093, 32'hC); checkOutput("bp.c", 1'b1, 32'h3, 3'd1, 1'b0, 32'hC);
    applyStimulus(1'b0, 32'h0, 32'h0); checkOutput("bp.empty", 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);

    $display("[TB] flush");
    out_ready = 1'b0;
    applyStimulus(1'b1, 32'h00400093, 32'hE1);
    applyStimulus(1'b1, 32'h00500093, 32'hE2);
    checkValue("fl.full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    applyStimulus(1'b1, 32'h00600093, 32'hD);
    flush = 1'b0;
    checkOutput("fl.cleared", 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    checkValue("fl.ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0); checkOutput("fl.no_d", 1'b0, 32'h0, 3'd0, 1'b0, 32'h0);
    applyStimulus(1'b1, 32'h00700093, 32'hF); checkOutput("fl.f", 1'b1, 32'h7, 3'd1, 1'b0, 32'hF);

    $display("[TB] asynchronous reset");
    applyStimulus(1'b1, 32'h00800093, 32'h20); checkOutput("ar.g", 1'b1, 32'h8, 3'd1, 1'b0, 32'h20);
    in_tag = 32'h21; inst_code = 32'h00900093;
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("ar.valid_now", 64'(out_valid), 64'd0);
    checkValue("ar.ready_now", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    checkValue("ar.valid_held", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkValue("ar.valid_post", 64'(out_valid), 64'd0);
    applyStimulus(1'b1, 32'h00A00093, 32'h22); checkOutput("ar.first", 1'b1, 32'hA, 3'd1, 1'b0, 32'h22);
    applyStimulus(1'b0, 32'h0, 32'h0);

    $display("[TB] XLEN=64 instance");
    in_valid64 = 1'b1; inst_code64 = 32'h800000B7; in_tag64 = 32'h40;
    @(posedge clk); #1;
    checkValue("x64.lui.valid", 64'(out_valid64), 64'd1);
    checkValue("x64.lui.imm", imm_out64, 64'hFFFFFFFF80000000);
    checkValue("x64.lui.fmt", 64'(fmt64), 64'd4);
    inst_code64 = 32'h03F09093; in_tag64 = 32'h44;
    @(posedge clk); #1;
    checkValue("x64.slli.imm", imm_out64, 64'd63);
    checkValue("x64.slli.fmt", 64'(fmt64), 64'd6);
    checkValue("x64.slli.tag", 64'(out_tag64), 64'h44);
    inst_code64 = 32'hFFF00093; in_tag64 = 32'h48;
    @(posedge clk); #1;
    checkValue("x64.addi.imm", imm_out64, 64'hFFFFFFFFFFFFFFFF);
    checkValue("x64.addi.illegal", 64'(illegal64), 64'd0);
    in_valid64 = 1'b0;
    @(posedge clk); #1;
    checkValue("x64.empty", 64'(out_valid64), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
